// File: rtl/cam_disp_pkg.sv
// Shared constants and types for the camera display buffer.
// Holds the 640x480@60 VGA timing, the capture window placement and size
// (also used by the camera writer), the pixel format and the control bundle
// that travels down the read-side delay line.
package cam_disp_pkg;

  // Horizontal timing in sysclk cycles (total 800)
  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;

  // Vertical timing in lines (total 525)
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;

  // Capture window, in active-area coordinates
  localparam int WIN_X0 = 270;
  localparam int WIN_Y0 = 190;
  localparam int WIN_W  = 100;
  localparam int WIN_H  = 100;

  localparam int ADDR_W = 16;
  localparam int PIX_W  = 3;
  localparam int RD_LAT = 1;
  localparam int CNT_W  = 10;

  typedef logic [PIX_W-1:0] pix_t;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam pix_t BORDER = 3'b000;

  // Per-pixel control decoded from the raster counters
  typedef struct packed {
    logic act;
    logic win;
    logic hs_n;
    logic vs_n;
    logic first;
  } vid_ctl_t;

  // Blanked, syncs inactive: the flushed state of every delay stage
  localparam vid_ctl_t CTL_IDLE = '{act: 1'b0, win: 1'b0, hs_n: 1'b1,
                                    vs_n: 1'b1, first: 1'b0};

  // True when v lies in [lo, lo+len-1]
  function automatic logic in_span(input cnt_t v, input int lo, input int len);
    return (int'(v) >= lo) && (int'(v) < lo + len);
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Raster counters for the VGA read side.
// Ports:
//   sysclk, rst        pixel clock, asynchronous active-high reset
//   o_hcnt, o_vcnt     current raster position (stage 0)
//   o_act              position lies in the active area
//   o_hs_n, o_vs_n     undelayed active-low sync decodes
//   o_first            position is (0,0)
//   o_vblank           registered vcnt >= V_ACTIVE, exact to the counter
module vga_timing_gen
  import cam_disp_pkg::*;
#(
  parameter int H_ACTIVE = cam_disp_pkg::H_ACTIVE,
  parameter int H_FP     = cam_disp_pkg::H_FP,
  parameter int H_SYNC   = cam_disp_pkg::H_SYNC,
  parameter int H_BP     = cam_disp_pkg::H_BP,
  parameter int V_ACTIVE = cam_disp_pkg::V_ACTIVE,
  parameter int V_FP     = cam_disp_pkg::V_FP,
  parameter int V_SYNC   = cam_disp_pkg::V_SYNC,
  parameter int V_BP     = cam_disp_pkg::V_BP
) (
  input  logic sysclk,
  input  logic rst,
  output cnt_t o_hcnt,
  output cnt_t o_vcnt,
  output logic o_act,
  output logic o_hs_n,
  output logic o_vs_n,
  output logic o_first,
  output logic o_vblank
);

  localparam int   H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int   V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam cnt_t H_LAST   = cnt_t'(H_TOTAL - 1);
  localparam cnt_t V_LAST   = cnt_t'(V_TOTAL - 1);
  localparam cnt_t H_ACT_C  = cnt_t'(H_ACTIVE);
  localparam cnt_t V_ACT_C  = cnt_t'(V_ACTIVE);

  cnt_t r_hcnt;
  cnt_t r_vcnt;
  logic r_vblank;

  logic w_h_last;
  cnt_t w_vcnt_nxt;

  // NOTE: every variable gets a default before any conditional assignment,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_h_last   = (r_hcnt == H_LAST);
    w_vcnt_nxt = r_vcnt;
    if (w_h_last) begin
      w_vcnt_nxt = (r_vcnt == V_LAST) ? '0 : r_vcnt + cnt_t'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      r_hcnt   <= '0;
      r_vcnt   <= '0;
      r_vblank <= 1'b0;
    end else begin
      r_hcnt   <= w_h_last ? '0 : r_hcnt + cnt_t'(1);
      r_vcnt   <= w_vcnt_nxt;
      // Computed from the next vcnt so it tracks r_vcnt on the same edge
      r_vblank <= (w_vcnt_nxt >= V_ACT_C);
    end
  end

  assign o_hcnt   = r_hcnt;
  assign o_vcnt   = r_vcnt;
  assign o_act    = (r_hcnt < H_ACT_C) && (r_vcnt < V_ACT_C);
  assign o_hs_n   = !in_span(r_hcnt, H_ACTIVE + H_FP, H_SYNC);
  assign o_vs_n   = !in_span(r_vcnt, V_ACTIVE + V_FP, V_SYNC);
  assign o_first  = (r_hcnt == '0) && (r_vcnt == '0);
  assign o_vblank = r_vblank;

endmodule

// File: rtl/ram2vga_reader.sv
// Read side of the camera display buffer.
// Generates VGA timing, reads the WIN_W x WIN_H window row-major from address
// 0 of the display RAM and drives the monitor. Blanking is black, active
// pixels outside the window show BORDER.
// Ports:
//   sysclk, rst        pixel clock, asynchronous active-high reset
//   rdaddr, rden       RAM read address / enable (enable only for window pixels)
//   q                  RAM read data, valid RD_LAT cycles after rdaddr/rden
//   hsync, vsync       active-low syncs, aligned with rgb
//   rgb                pixel colour {r,g,b}
//   vblank             undelayed vcnt >= V_ACTIVE, for the writer
//   frame_start        one-cycle pulse with output pixel (0,0)
module ram2vga_reader
  import cam_disp_pkg::*;
#(
  parameter int   H_ACTIVE = cam_disp_pkg::H_ACTIVE,
  parameter int   H_FP     = cam_disp_pkg::H_FP,
  parameter int   H_SYNC   = cam_disp_pkg::H_SYNC,
  parameter int   H_BP     = cam_disp_pkg::H_BP,
  parameter int   V_ACTIVE = cam_disp_pkg::V_ACTIVE,
  parameter int   V_FP     = cam_disp_pkg::V_FP,
  parameter int   V_SYNC   = cam_disp_pkg::V_SYNC,
  parameter int   V_BP     = cam_disp_pkg::V_BP,
  parameter int   WIN_X0   = cam_disp_pkg::WIN_X0,
  parameter int   WIN_Y0   = cam_disp_pkg::WIN_Y0,
  parameter int   WIN_W    = cam_disp_pkg::WIN_W,
  parameter int   WIN_H    = cam_disp_pkg::WIN_H,
  parameter int   ADDR_W   = cam_disp_pkg::ADDR_W,
  parameter int   RD_LAT   = cam_disp_pkg::RD_LAT,
  parameter pix_t BORDER   = cam_disp_pkg::BORDER
) (
  input  logic              sysclk,
  input  logic              rst,
  output logic [ADDR_W-1:0] rdaddr,
  output logic              rden,
  input  pix_t              q,
  output logic              hsync,
  output logic              vsync,
  output pix_t              rgb,
  output logic              vblank,
  output logic              frame_start
);

  // Counters -> address register -> RAM (RD_LAT) -> output register
  localparam int PIPE = 2 + RD_LAT;
  // Control stages ahead of the output register
  localparam int DLY  = PIPE - 1;

  cnt_t w_hcnt;
  cnt_t w_vcnt;
  logic w_act;
  logic w_hs_n;
  logic w_vs_n;
  logic w_first;
  logic w_win;
  logic w_addr_clr;

  vid_ctl_t w_ctl;
  vid_ctl_t w_tail;

  logic [ADDR_W-1:0] r_rdaddr;
  logic [ADDR_W-1:0] r_next;
  logic              r_rden;
  vid_ctl_t          r_ctl [DLY];

  vga_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .sysclk   (sysclk),
    .rst      (rst),
    .o_hcnt   (w_hcnt),
    .o_vcnt   (w_vcnt),
    .o_act    (w_act),
    .o_hs_n   (w_hs_n),
    .o_vs_n   (w_vs_n),
    .o_first  (w_first),
    .o_vblank (vblank)
  );

  always_comb begin
    w_win = w_act
         && in_span(w_hcnt, WIN_X0, WIN_W)
         && in_span(w_vcnt, WIN_Y0, WIN_H);
    // Start of vertical blanking: the writer may now refill, rewind reads
    w_addr_clr = (w_hcnt == '0) && (w_vcnt == cnt_t'(V_ACTIVE));
    w_ctl = '{act: w_act, win: w_win, hs_n: w_hs_n, vs_n: w_vs_n,
              first: w_first};
    w_tail = r_ctl[DLY-1];
  end

  // Stage 1: read address generation. The window is only inside the active
  // area, so the rewind never coincides with a window pixel.
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      r_rden   <= 1'b0;
      r_rdaddr <= '0;
      r_next   <= '0;
    end else begin
      r_rden <= w_win;
      if (w_addr_clr) begin
        r_rdaddr <= '0;
        r_next   <= '0;
      end else if (w_win) begin
        r_rdaddr <= r_next;
        r_next   <= r_next + ADDR_W'(1);
      end
    end
  end

  // Control delay line matching the address register plus RAM latency.
  // NOTE: this small shift register is reset on purpose so a reset flushes
  // any half-drawn pixels; bulk storage (the RAM itself) is never reset.
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DLY; i++) r_ctl[i] <= CTL_IDLE;
    end else begin
      r_ctl[0] <= w_ctl;
      for (int i = 1; i < DLY; i++) r_ctl[i] <= r_ctl[i-1];
    end
  end

  // Output register: q reaches rgb only for window pixels
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      rgb         <= '0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      rgb         <= !w_tail.act ? '0 : (w_tail.win ? q : BORDER);
      hsync       <= w_tail.hs_n;
      vsync       <= w_tail.vs_n;
      frame_start <= w_tail.first;
    end
  end

  assign rdaddr = r_rdaddr;
  assign rden   = r_rden;

endmodule
